// File: rtl/result_frame_tx.sv
// Serializes a latched 27-bit signed result as a 6-byte 8N1 UART frame:
// header, four little-endian sign-extended bytes, XOR checksum.
`timescale 1ns/1ps

module result_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [26:0] result,
  output logic        busy,
  output logic        done,
  output logic        uart_txd
);

  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'd5;
  localparam logic [2:0]  LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [26:0]      data_q, data_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [31:0]      ext_c;
  logic [7:0]       chk_c;
  logic [7:0]       byte_c;
  logic             bit_end_c;

  // Byte mux and checksum, driven only by the latched result
  always_comb begin
    ext_c = {{5{data_q[26]}}, data_q};
    chk_c = HEADER ^ ext_c[7:0] ^ ext_c[15:8] ^ ext_c[23:16] ^ ext_c[31:24];
    case (byte_idx_q)
      3'd0:    byte_c = HEADER;
      3'd1:    byte_c = ext_c[7:0];
      3'd2:    byte_c = ext_c[15:8];
      3'd3:    byte_c = ext_c[23:16];
      3'd4:    byte_c = ext_c[31:24];
      default: byte_c = chk_c;
    endcase
  end

  assign bit_end_c = (clk_cnt_q == CNT_LAST);

  // State register; line and status flags are registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      data_q     <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; the value placed on txd_d is what the line shows in the new state
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = START_BIT;
          data_d     = result;
          clk_cnt_d  = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START_BIT: begin
        if (bit_end_c) begin
          state_d   = DATA_BITS;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          txd_d     = byte_c[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      DATA_BITS: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP_BIT;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = byte_c[3'(bit_idx_q + 3'd1)];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      STOP_BIT: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          if (byte_idx_q == LAST_BYTE) begin
            state_d    = IDLE;
            byte_idx_d = '0;
            txd_d      = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d    = START_BIT;
            byte_idx_d = byte_idx_q + 3'd1;
            txd_d      = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/result_frame_tx.md
Name: result_frame_tx

Overview:
Transmit-side counterpart of the UART frame assembly in front of the network. Takes one 27-bit signed network result on a start pulse and serializes it as a fixed 6-byte frame over an 8N1 UART line. The bit-level serializer is built in. Sits between Network.out_2/end_2 and the UART TX pin, replacing the single-bit result path.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2
HEADER, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to send; sampled only when idle
result  input  27  signed network result, latched on accepted start
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when the last stop bit completes
uart_txd  output  1  serial line, idle high

Behaviour:
- Reset (async, rst_n=0), taking effect immediately even mid-frame:
  - uart_txd=1, busy=0, done=0, FSM in IDLE, all counters cleared.
  - No partial frame resumes after reset release.
- Frame format: 6 bytes, in order:
  - HEADER
  - B0, B1, B2, B3: little-endian bytes of result sign-extended to 32 bits (bits 31:27 = result[26]).
  - CHK = HEADER ^ B0 ^ B1 ^ B2 ^ B3.
- Byte format, 8N1:
  - Start bit 0, data bits LSB first, stop bit 1.
  - Each bit held exactly CLKS_PER_BIT cycles.
  - Next byte's start bit follows the previous stop bit with no idle gap.
  - Frame length = 60*CLKS_PER_BIT cycles.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - IDLE -> START_BIT: on start=1. result is latched and busy=1 from the next cycle. uart_txd falls in the cycle after start is sampled (1-cycle latency).
  - START_BIT -> DATA_BITS: after CLKS_PER_BIT cycles.
  - DATA_BITS -> STOP_BIT: after 8 bits; bit index counter is 0..7.
  - STOP_BIT -> START_BIT: after CLKS_PER_BIT cycles, if byte index < 5. Byte index increments.
  - STOP_BIT -> IDLE: after CLKS_PER_BIT cycles, if byte index = 5. In that same cycle done=1 and busy=0.
- start while busy: ignored, no queuing, latched result unchanged.
- start in the done cycle: accepted, since busy=0 there. Back-to-back frames have one idle-high cycle between the last stop bit and the next start bit.
- result may change freely after the accepted start cycle without affecting the frame.
- uart_txd is registered (glitch-free).
- CHK and the byte mux are computed from the latched value only.
- Bit counter wraps 0..CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT).

Test Plan:
- Reset/idle: hold rst_n=0, then release with start=0 for 100 cycles -> uart_txd=1, busy=0, done never pulses.
- Positive value (CLKS_PER_BIT=4): result=27'h0000123, start pulse -> line decodes A5 23 01 00 00 87. busy high for exactly 240 cycles. done is a single pulse at the end.
- Negative sign extension: result=27'h7FFFFFF (-1) -> A5 FF FF FF FF A5. Then result=27'h4000000 -> A5 00 00 00 FC 59.
- start during busy: pulse start with a different result at byte 2 -> frame unchanged, no second frame follows.
- Back-to-back: assert start in the done cycle with result=27'h0000001 -> exactly one idle-high cycle, then second frame A5 01 00 00 00 A4.
- Reset mid-frame: drop rst_n during DATA_BITS of byte 3 -> uart_txd=1 and busy=0 asynchronously. After release, a new start sends a complete correct frame.
